// File: rtl/fmc_pkg.sv
// fmc_window_cmp shared types and default sizes.
// Optional build macro FMC_SYNC_EN is consumed by fmc_edge_det.
package fmc_pkg;

  localparam int MW_DEF       = 8;
  localparam int NW_DEF       = 10;
  localparam int TW_DEF       = 4;
  localparam int LOCK_WIN_DEF = 4;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_DN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    EVAL
  } fmc_state_e;

endpackage

// File: rtl/fmc_window_cmp_if.sv
// Config/decision bundle between the feedback divider side
// and the window comparator.
interface fmc_window_cmp_if #(
  parameter int MW = fmc_pkg::MW_DEF,
  parameter int NW = fmc_pkg::NW_DEF,
  parameter int TW = fmc_pkg::TW_DEF
) ();

  logic          en;
  logic          fb_in;
  logic [MW-1:0] m_win;
  logic [NW-1:0] n_target;
  logic [TW-1:0] tol;
  logic [1:0]    sel;
  logic          sel_valid;
  logic          locked;
  logic [NW-1:0] edge_cnt;
  logic          busy;

  modport master (
    output en, fb_in, m_win, n_target, tol,
    input  sel, sel_valid, locked, edge_cnt, busy
  );

  modport slave (
    input  en, fb_in, m_win, n_target, tol,
    output sel, sel_valid, locked, edge_cnt, busy
  );

endinterface

// File: rtl/fmc_edge_det.sv
// Rising-edge detector for fb_in.
// FMC_SYNC_EN adds a 2-flop synchronizer in front (2 cycles more latency).
module fmc_edge_det (
  input  logic clk_ext,
  input  logic rst_n,
  input  logic fb_in,
  output logic rise
);

  logic fb_s;
  logic fb_prev;

`ifdef FMC_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_ext) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], fb_in};
  end

  assign fb_s = sync_q[1];
`else
  assign fb_s = fb_in;
`endif

  always_ff @(posedge clk_ext) begin
    if (!rst_n) fb_prev <= 1'b0;
    else        fb_prev <= fb_s;
  end

  assign rise = fb_s & ~fb_prev;

endmodule

// File: rtl/fmc_window_cmp.sv
// Feedback edge counter over an m_win-cycle window with band compare.
// Build option: FMC_SYNC_EN synchronizes fb_in before edge detect.
module fmc_window_cmp
  import fmc_pkg::*;
#(
  parameter int MW       = MW_DEF,
  parameter int NW       = NW_DEF,
  parameter int TW       = TW_DEF,
  parameter int LOCK_WIN = LOCK_WIN_DEF
) (
  input  logic            clk_ext,
  input  logic            rst_n,
  fmc_window_cmp_if.slave bus
);

  localparam int LCW = $clog2(LOCK_WIN + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_WIN);
  localparam logic [MW-1:0]  M_ONE    = MW'(1);

  fmc_state_e     state_q, state_d;
  logic [MW-1:0]  win_q, win_d;
  logic [MW-1:0]  m_lat_q, m_lat_d;
  logic [NW-1:0]  acc_q, acc_d;
  logic [NW-1:0]  n_lat_q, n_lat_d;
  logic [NW-1:0]  edge_q, edge_d;
  logic [TW-1:0]  tol_lat_q, tol_lat_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic [1:0]     sel_q, sel_d;
  logic           valid_q, valid_d;
  logic           locked_q, locked_d;
  logic           start;
  logic           rise;

  logic [NW:0] acc_x, n_x, tol_x;
  logic [NW:0] low, high;
  logic [1:0]  verdict;

  fmc_edge_det u_edge (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .fb_in   (bus.fb_in),
    .rise    (rise)
  );

  // One extra bit so n+tol never wraps
  assign acc_x = {1'b0, acc_q};
  assign n_x   = {1'b0, n_lat_q};
  assign tol_x = {{(NW + 1 - TW){1'b0}}, tol_lat_q};
  assign low   = (n_x > tol_x) ? n_x - tol_x : '0;
  assign high  = n_x + tol_x;

  always_comb begin
    verdict = SEL_HOLD;
    unique case (1'b1)
      acc_x < low:  verdict = SEL_UP;
      acc_x > high: verdict = SEL_DN;
      default:      verdict = SEL_HOLD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    m_lat_d   = m_lat_q;
    acc_d     = acc_q;
    n_lat_d   = n_lat_q;
    tol_lat_d = tol_lat_q;
    edge_d    = edge_q;
    lock_d    = lock_q;
    sel_d     = sel_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    start     = 1'b0;

    unique case (state_q)
      IDLE: start = bus.en;
      MEASURE: begin
        if (!bus.en) begin
          state_d  = IDLE;
          lock_d   = '0;
          locked_d = 1'b0;
        end else begin
          win_d = win_q + 1'b1;
          if (rise && acc_q != '1) acc_d = acc_q + 1'b1;
          if (win_q == m_lat_q - M_ONE) state_d = EVAL;
        end
      end
      EVAL: begin
        sel_d   = verdict;
        edge_d  = acc_q;
        valid_d = 1'b1;
        if (verdict == SEL_HOLD) begin
          if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
          if (lock_d == LOCK_MAX) locked_d = 1'b1;
        end else begin
          lock_d   = '0;
          locked_d = 1'b0;
        end
        state_d = IDLE;
        start   = bus.en;
      end
      default: state_d = IDLE;
    endcase

    // Back-to-back windows re-latch config here
    if (start) begin
      m_lat_d   = (bus.m_win == '0) ? M_ONE : bus.m_win;
      n_lat_d   = bus.n_target;
      tol_lat_d = bus.tol;
      win_d     = '0;
      acc_d     = '0;
      state_d   = MEASURE;
    end
  end

  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      m_lat_q   <= '0;
      acc_q     <= '0;
      n_lat_q   <= '0;
      tol_lat_q <= '0;
      edge_q    <= '0;
      lock_q    <= '0;
      sel_q     <= SEL_HOLD;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      m_lat_q   <= m_lat_d;
      acc_q     <= acc_d;
      n_lat_q   <= n_lat_d;
      tol_lat_q <= tol_lat_d;
      edge_q    <= edge_d;
      lock_q    <= lock_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.locked    = locked_q;
  assign bus.edge_cnt  = edge_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
